// File: rtl/video_frame_scheduler.sv
// video_frame_scheduler: two-requester round-robin pixel FIFO feeding a
// raster-tracked scanout stream, with black fill and sticky flag on underflow.
module video_frame_scheduler #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned H640  = 640,
    parameter int unsigned V640  = 480,
    parameter int unsigned H1280 = 1280,
    parameter int unsigned V1280 = 720
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               res_switch,
    input  logic                     req0_valid,
    input  logic [23:0]              req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [23:0]              req1_data,
    output logic                     req1_ready,
    input  logic                     pix_tick,
    output logic [23:0]              frame,
    output logic [10:0]              px_x,
    output logic [9:0]               px_y,
    output logic                     sof,
    output logic                     underflow,
    input  logic                     clr_underflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rr_ptr;
    logic          mode;
    logic [10:0]   cnt_x;
    logic [9:0]    cnt_y;

    logic          full;
    logic          empty;
    logic          grant0;
    logic          grant1;
    logic          push;
    logic [23:0]   push_data;
    logic          pop;
    logic          pop_hit;
    logic [10:0]   h_last;
    logic [9:0]    v_last;

    // Arbitration, FIFO status and raster limits for the active mode
    always_comb begin
        full       = (fifo_count == CW'(DEPTH));
        empty      = (fifo_count == '0);
        grant0     = req0_valid & (~rr_ptr | ~req1_valid);
        grant1     = req1_valid & (rr_ptr | ~req0_valid);
        req0_ready = grant0 & ~full;
        req1_ready = grant1 & ~full;
        push       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        push_data  = grant0 ? req0_data : req1_data;
        pop        = pix_tick & enable;
        pop_hit    = pop & ~empty;
        h_last     = mode ? 11'(H1280 - 1) : 11'(H640 - 1);
        v_last     = mode ? 10'(V1280 - 1) : 10'(V640 - 1);
    end

    // Pixel storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, arbitration pointer, scanout, raster position and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rr_ptr     <= 1'b0;
            mode       <= 1'b0;
            cnt_x      <= '0;
            cnt_y      <= '0;
            frame      <= 24'h000000;
            px_x       <= '0;
            px_y       <= '0;
            sof        <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= grant0;
            end
            if (pop_hit) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop_hit);

            if (pop) begin
                frame <= pop_hit ? mem[rd_ptr] : 24'h000000;
                px_x  <= cnt_x;
                px_y  <= cnt_y;
                sof   <= (cnt_x == '0) && (cnt_y == '0);
                if (cnt_x == h_last) begin
                    cnt_x <= '0;
                    cnt_y <= (cnt_y == v_last) ? '0 : cnt_y + 1'b1;
                end else begin
                    cnt_x <= cnt_x + 1'b1;
                end
            end else begin
                sof <= 1'b0;
            end

            if (pop && empty) begin
                underflow <= 1'b1;
            end else if (clr_underflow) begin
                underflow <= 1'b0;
            end

            // Resolution only changes while the next pixel is the frame origin
            if ((cnt_x == '0) && (cnt_y == '0)) begin
                mode <= (res_switch == 2'd1);
            end
        end
    end

endmodule

// File: doc/video_frame_scheduler.md
Name: video_frame_scheduler

Overview:
Sits between pixel producers and video_controller's 24-bit frame input. Arbitrates pixel writes from two requesters (CPU bus bridge, DMA) into a pixel FIFO. Drains one pixel per pixel tick while tracking raster position for the active resolution. Emits black on underflow and records the event.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
H640, 640, active width, mode 0
V640, 480, active height, mode 0
H1280, 1280, active width, mode 1
V1280, 720, active height, mode 1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scanout enable
res_switch  in  2  requested mode: 0=640x480, 1=1280x720, 2/3 treated as 0
req0_valid  in  1  requester 0 has a pixel
req0_data  in  24  requester 0 RGB pixel
req0_ready  out  1  requester 0 pixel accepted this cycle when valid
req1_valid  in  1  requester 1 has a pixel
req1_data  in  24  requester 1 RGB pixel
req1_ready  out  1  requester 1 pixel accepted this cycle when valid
pix_tick  in  1  one pixel consumed this cycle
frame  out  24  current pixel to video_controller
px_x  out  11  column of pixel on frame
px_y  out  10  row of pixel on frame
sof  out  1  one-cycle pulse with pixel (0,0)
underflow  out  1  sticky underflow flag
clr_underflow  in  1  clears underflow
fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values: frame=0, px_x=0, px_y=0, sof=0, underflow=0, fifo_count=0, FIFO empty, active mode=0, round-robin pointer favours req0. Reset mid-operation discards FIFO contents and the raster position.
- Arbitration: at most one push per cycle. Grant is combinational from valids and the pointer.
  - Both valid: the pointer side wins.
  - One valid: that side wins.
- reqN_ready = grantN & ~full. Transfer = reqN_valid & reqN_ready.
- After each transfer, the pointer moves to the other requester. The pointer holds when there is no transfer.
- Ready depends only on full. There is no pop-to-push bypass: when full, ready is low even if a pop occurs the same cycle.
- Pop: occurs on pix_tick & enable. Latency is one cycle; frame, px_x, px_y and sof update on the clock edge after the tick.
  - FIFO non-empty: frame <= head; the entry is removed.
  - FIFO empty: frame <= 24'h000000 and underflow <= 1. There is no push-to-pop bypass, so a push into an empty FIFO in the same cycle still underflows, and the pushed pixel remains stored.
- Simultaneous push and pop with FIFO non-empty: fifo_count unchanged; FIFO order preserved.
- Raster position: a counter advances on every pix_tick & enable, whether or not the FIFO is empty.
  - x wraps from H-1 to 0 and increments y.
  - y wraps from V-1 to 0.
  - px_x/px_y report the position of the pixel loaded into frame.
  - sof=1 exactly in the cycle frame holds pixel (0,0); otherwise 0.
- Mode change: res_switch is sampled into the active mode only when the next pixel position is (0,0), i.e. at a frame boundary, and after reset. A mid-frame change takes effect at the next frame.
- enable=0: no pops, counters hold, frame/px_x/px_y hold, sof=0. Pushes continue.
- Underflow flag: clr_underflow clears it. If a clear and a new underflow occur in the same cycle, set wins.
- FIFO: circular pointers of $clog2(DEPTH) bits wrap at DEPTH. full = (count==DEPTH); empty = (count==0).

Test Plan:
1. Reset, then req0 pushes 3 pixels 0x112233/0x445566/0x778899, then 3 pix_ticks with enable=1. Required: frame shows them in order, each one cycle after its tick; px_x=0,1,2; sof=1 only with 0x112233; fifo_count returns to 0.
2. req0 and req1 valid continuously with FIFO having space. Required: grants alternate req0,req1,req0,...; exactly one ready per cycle.
3. Fill FIFO to 16 with no ticks. Required: both readies low; fifo_count=16. Then tick and push in the same cycle: push refused that cycle, accepted the next cycle.
4. Empty FIFO with pix_tick. Required: frame=0; underflow=1 and stays 1. Then clr_underflow with no tick: underflow=0. Clear and underflow together: underflow=1.
5. Mode 0, tick 640 times. Required: px_x wraps 639->0 and px_y=1. Then 640*479 more ticks: sof pulses at the next (0,0).
6. Set res_switch=1 at px_x=100. Required: mode 0 wraps continue until the frame ends, then the next frame wraps at x=1279, y=719. With res_switch=3, mode 0 wraps apply.
